falling_box_mover: RTL and testbench

Moves the game's falling 4×4 box by one pixel on each move pulse from the frame-interval counter (one pulse every 15 frames at 60 Hz). For every move it drives the VGA adapter plot port through a fixed sequence: erase the old box, step the position, draw the new box. It also reports when the box reaches the landing row, so the game controller can score and restart the round.

---
 rtl/falling_box_mover.sv | 104 ++++++++++
 tb/tb_falling_box_mover.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/falling_box_mover.sv
// Falling 4x4 box mover: erases the box, steps it down one row and
// redraws it through the VGA plot port on every move request.
module falling_box_mover #(
    parameter logic [7:0] X_START   = 8'd78,
    parameter logic [6:0] Y_START   = 7'd0,
    parameter logic [6:0] Y_LIMIT   = 7'd112,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       move_tick,
    input  logic       restart,
    input  logic [2:0] colour_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       landed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_UPDATE,
        S_DRAW,
        S_LANDED
    } state_t;

    state_t     state;
    logic [6:0] pos_y;
    logic [2:0] box_colour;
    logic [3:0] cnt;
    logic       pending;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            pos_y      <= Y_START;
            box_colour <= 3'b000;
            cnt        <= 4'd0;
            pending    <= 1'b0;
        end else if (restart) begin
            // restart wins over any tick or sequence in flight
            state      <= S_DRAW;
            pos_y      <= Y_START;
            box_colour <= colour_in;
            cnt        <= 4'd0;
            pending    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (move_tick || pending) begin
                        state   <= S_ERASE;
                        cnt     <= 4'd0;
                        pending <= 1'b0;
                    end
                end
                S_ERASE: begin
                    if (move_tick)
                        pending <= 1'b1;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15)
                        state <= S_UPDATE;
                end
                S_UPDATE: begin
                    if (move_tick)
                        pending <= 1'b1;
                    pos_y      <= pos_y + 7'd1;
                    box_colour <= colour_in;
                    cnt        <= 4'd0;
                    state      <= S_DRAW;
                end
                S_DRAW: begin
                    if (move_tick)
                        pending <= 1'b1;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        if (pos_y == Y_LIMIT)
                            state <= S_LANDED;
                        else
                            state <= S_IDLE;
                    end
                end
                S_LANDED: begin
                    state <= S_LANDED;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // row-major walk over the 4x4 box
    assign x      = X_START + {6'd0, cnt[1:0]};
    assign y      = pos_y + {5'd0, cnt[3:2]};
    assign colour = (state == S_ERASE) ? BG_COLOUR : box_colour;
    assign plot   = (state == S_ERASE) || (state == S_DRAW);
    assign busy   = (state == S_ERASE) || (state == S_UPDATE)
                 || (state == S_DRAW);
    assign landed = (state == S_LANDED);

endmodule

// File: tb/tb_falling_box_mover.sv
// Directed bench for falling_box_mover: default instance plus one
// started near the landing row.
module tb_falling_box_mover;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       a_tick = 1'b0, a_restart = 1'b0;
    logic [2:0] a_colour_in = 3'd0;
    logic [7:0] a_x;
    logic [6:0] a_y;
    logic [2:0] a_colour;
    logic       a_plot, a_busy, a_landed;
    logic       b_tick = 1'b0, b_restart = 1'b0;
    logic [2:0] b_colour_in = 3'd0;
    logic [7:0] b_x;
    logic [6:0] b_y;
    logic [2:0] b_colour;
    logic       b_plot, b_busy, b_landed;

    logic       use_b = 1'b0;
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_colour;
    logic       m_plot, m_busy, m_landed;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clock = ~clock;

    falling_box_mover dut_a (
        .clock(clock), .resetn(resetn),
        .move_tick(a_tick), .restart(a_restart), .colour_in(a_colour_in),
        .x(a_x), .y(a_y), .colour(a_colour),
        .plot(a_plot), .busy(a_busy), .landed(a_landed)
    );

    falling_box_mover #(.Y_START(7'd111)) dut_b (
        .clock(clock), .resetn(resetn),
        .move_tick(b_tick), .restart(b_restart), .colour_in(b_colour_in),
        .x(b_x), .y(b_y), .colour(b_colour),
        .plot(b_plot), .busy(b_busy), .landed(b_landed)
    );

    assign m_x      = use_b ? b_x : a_x;
    assign m_y      = use_b ? b_y : a_y;
    assign m_colour = use_b ? b_colour : a_colour;
    assign m_plot   = use_b ? b_plot : a_plot;
    assign m_busy   = use_b ? b_busy : a_busy;
    assign m_landed = use_b ? b_landed : a_landed;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // checks n consecutive plot cycles of a box at row y0
    task automatic expect_box(input string tag, input int y0,
                              input logic [2:0] col, input int n);
        logic [7:0] ex;
        logic [6:0] ey;
        for (int i = 0; i < n; i++) begin
            ex = 8'(78 + i % 4);
            ey = 7'(y0 + i / 4);
            check($sformatf("%s[%0d]", tag, i),
                  {12'd0, m_busy, m_plot, m_x, m_y, m_colour},
                  {12'd0, 1'b1, 1'b1, ex, ey, col});
            @(negedge clock);
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (m_busy && n < 200) begin
            n++;
            @(negedge clock);
        end
    endtask

    initial begin
        int n;
        int plots;

        repeat (2) @(negedge clock);
        check("rst_a", {29'd0, a_plot, a_busy, a_landed}, 32'd0);
        check("rst_b", {29'd0, b_plot, b_busy, b_landed}, 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        check("idle_a", {30'd0, a_plot, a_busy}, 32'd0);

        // instance B: land after one move from row 111
        use_b = 1'b1;
        b_colour_in = 3'd5;
        b_restart = 1'b1;
        @(negedge clock);
        b_restart = 1'b0;
        expect_box("b_rst", 111, 3'd5, 16);
        check("b_rst_end", {30'd0, m_busy, m_landed}, 32'd0);
        b_tick = 1'b1;
        @(negedge clock);
        b_tick = 1'b0;
        expect_box("b_erase", 111, 3'd0, 16);
        @(negedge clock);
        expect_box("b_draw", 112, 3'd5, 16);
        check("b_landed", {30'd0, m_busy, m_landed}, 32'd1);
        plots = 0;
        for (int i = 0; i < 40; i++) begin
            b_tick = (i % 5 == 0);
            @(negedge clock);
            if (m_plot) plots++;
        end
        b_tick = 1'b0;
        check("b_no_plot", plots, 0);
        check("b_still_landed", {31'd0, m_landed}, 32'd1);
        b_restart = 1'b1;
        @(negedge clock);
        b_restart = 1'b0;
        expect_box("b_rst2", 111, 3'd5, 16);
        check("b_unlanded", {30'd0, m_busy, m_landed}, 32'd0);

        // instance A
        use_b = 1'b0;
        a_colour_in = 3'd4;
        a_restart = 1'b1;
        @(negedge clock);
        a_restart = 1'b0;
        expect_box("a_rst", 0, 3'd4, 16);
        check("a_rst_end", {29'd0, m_plot, m_busy, m_landed}, 32'd0);

        a_tick = 1'b1;
        @(negedge clock);
        a_tick = 1'b0;
        expect_box("a_erase0", 0, 3'd0, 16);
        check("a_update", {30'd0, m_plot, m_busy}, 32'd1);
        @(negedge clock);
        expect_box("a_draw1", 1, 3'd4, 16);
        check("a_move_end", {30'd0, m_plot, m_busy}, 32'd0);

        // three extra ticks during ERASE collapse into one pending move
        a_tick = 1'b1;
        @(negedge clock);
        n = 0;
        while (m_busy && n < 200) begin
            a_tick = (n < 3);
            n++;
            @(negedge clock);
        end
        a_tick = 1'b0;
        check("pend_busy1", n, 33);
        check("pend_idle", {31'd0, m_busy}, 32'd0);
        @(negedge clock);
        check("pend_restart", {31'd0, m_busy}, 32'd1);
        count_busy(n);
        check("pend_busy2", n, 33);
        repeat (3) @(negedge clock);
        check("pend_done", {31'd0, m_busy}, 32'd0);

        // box now at row 3; restart with tick part-way through DRAW
        a_tick = 1'b1;
        @(negedge clock);
        a_tick = 1'b0;
        expect_box("a_erase3", 3, 3'd0, 16);
        @(negedge clock);
        expect_box("a_draw4", 4, 3'd4, 5);
        a_restart = 1'b1;
        a_tick = 1'b1;
        a_colour_in = 3'd2;
        @(negedge clock);
        a_restart = 1'b0;
        a_tick = 1'b0;
        expect_box("a_rst_mid", 0, 3'd2, 16);
        check("rst_mid_end", {30'd0, m_busy, m_landed}, 32'd0);
        repeat (4) @(negedge clock);
        check("rst_tick_dropped", {30'd0, m_busy, m_plot}, 32'd0);

        // move to row 1, then reset part-way through the next erase
        a_tick = 1'b1;
        @(negedge clock);
        a_tick = 1'b0;
        expect_box("a_erase0b", 0, 3'd0, 16);
        @(negedge clock);
        expect_box("a_draw1b", 1, 3'd2, 16);
        a_tick = 1'b1;
        @(negedge clock);
        a_tick = 1'b0;
        expect_box("a_erase1", 1, 3'd0, 3);
        #3 resetn = 1'b0;
        #1;
        check("async_rst", {29'd0, m_plot, m_busy, m_landed}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("post_rst_idle", {30'd0, m_plot, m_busy}, 32'd0);
        a_colour_in = 3'd7;
        a_tick = 1'b1;
        @(negedge clock);
        a_tick = 1'b0;
        expect_box("post_rst_erase", 0, 3'd0, 16);
        @(negedge clock);
        expect_box("post_rst_draw", 1, 3'd7, 16);
        check("post_rst_end", {30'd0, m_busy, m_landed}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
